// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants for the GPU register file.
//   GPU_DATA_WIDTH / GPU_REG_ADDR_WIDTH / GPU_THREADS: default geometry.
//   CLR_*: clear-engine FSM state encoding.
//   tid_width(): thread-id width, never below one bit.
package gpu_pkg;

    localparam int unsigned GPU_DATA_WIDTH     = 64;
    localparam int unsigned GPU_REG_ADDR_WIDTH = 4;
    localparam int unsigned GPU_THREADS        = 4;

    localparam logic [1:0] CLR_IDLE  = 2'd0;
    localparam logic [1:0] CLR_CLEAR = 2'd1;
    localparam logic [1:0] CLR_DONE  = 2'd2;

    function automatic int unsigned tid_width(input int unsigned threads);
        return (threads > 1) ? $clog2(threads) : 1;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential context clear engine.
//   clk, rst_n      : clock, synchronous active-low reset
//   clr_req/clr_tid : start request and target thread (taken only when idle)
//   clr_busy        : engine in CLEAR or DONE
//   clr_done        : one-cycle pulse in DONE
//   zero_we/tid/addr: zero-write command issued once per CLEAR cycle
module regfile_clr_fsm
    import gpu_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = GPU_REG_ADDR_WIDTH,
    parameter int unsigned TID_W          = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_req,
    input  logic [TID_W-1:0]          clr_tid,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic                      zero_we,
    output logic [TID_W-1:0]          zero_tid,
    output logic [REG_ADDR_WIDTH-1:0] zero_addr
);

    logic [1:0]                state_q, state_d;
    logic [TID_W-1:0]          tid_q, tid_d;
    logic [REG_ADDR_WIDTH-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        tid_d   = tid_q;
        idx_d   = idx_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_CLEAR;
                    tid_d   = clr_tid;
                    idx_d   = '0;
                end
            end
            CLR_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            tid_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tid_q   <= tid_d;
            idx_q   <= idx_d;
        end
    end

    assign clr_busy  = (state_q != CLR_IDLE);
    assign clr_done  = (state_q == CLR_DONE);
    assign zero_we   = (state_q == CLR_CLEAR);
    assign zero_tid  = tid_q;
    assign zero_addr = idx_q;

endmodule

// File: rtl/gpu_regfile_mt.sv
// gpu_regfile_mt: multi-context register file, one context per hardware thread.
//   clk, rst_n              : clock, synchronous active-low reset
//   w0_* / w1_*             : write ports; w0 (ALU) beats w1 (load return)
//   r_tid / r_addr / r_data : NREAD packed combinational read ports
//   clr_req / clr_tid       : request a sequential zeroing of one context
//   clr_busy / clr_done     : clear engine status
module gpu_regfile_mt
    import gpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = GPU_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = GPU_REG_ADDR_WIDTH,
    parameter int unsigned THREADS        = GPU_THREADS,
    parameter int unsigned NREAD          = 2,
    parameter int unsigned ZERO_REG       = 1,
    localparam int unsigned TID_W         = tid_width(THREADS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            w0_en,
    input  logic [TID_W-1:0]                w0_tid,
    input  logic [REG_ADDR_WIDTH-1:0]       w0_addr,
    input  logic [DATA_WIDTH-1:0]           w0_data,
    input  logic                            w1_en,
    input  logic [TID_W-1:0]                w1_tid,
    input  logic [REG_ADDR_WIDTH-1:0]       w1_addr,
    input  logic [DATA_WIDTH-1:0]           w1_data,
    input  logic [NREAD*TID_W-1:0]          r_tid,
    input  logic [NREAD*REG_ADDR_WIDTH-1:0] r_addr,
    output logic [NREAD*DATA_WIDTH-1:0]     r_data,
    input  logic                            clr_req,
    input  logic [TID_W-1:0]                clr_tid,
    output logic                            clr_busy,
    output logic                            clr_done
);

    localparam int unsigned NREGS = 1 << REG_ADDR_WIDTH;
    localparam int unsigned DEPTH = THREADS * NREGS;
    localparam int unsigned IDX_W = TID_W + REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                      zero_we;
    logic [TID_W-1:0]          lock_tid;
    logic [REG_ADDR_WIDTH-1:0] zero_addr;
    logic                      w0_ok, w1_ok;
    logic [IDX_W-1:0]          w0_idx, w1_idx, zero_idx;

    function automatic logic tid_ok(input logic [TID_W-1:0] t);
        return 32'(t) < THREADS;
    endfunction

    function automatic logic is_zero_reg(input logic [REG_ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    regfile_clr_fsm #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .TID_W          (TID_W)
    ) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .clr_tid   (clr_tid),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .zero_we   (zero_we),
        .zero_tid  (lock_tid),
        .zero_addr (zero_addr)
    );

    // A write is live only if it will actually commit; bypass uses the same
    // qualification so reads never show a write that storage will drop.
    always_comb begin
        w0_ok = rst_n && w0_en && tid_ok(w0_tid) && !is_zero_reg(w0_addr)
                && !(clr_busy && (w0_tid == lock_tid));
        w1_ok = rst_n && w1_en && tid_ok(w1_tid) && !is_zero_reg(w1_addr)
                && !(clr_busy && (w1_tid == lock_tid));
    end

    assign w0_idx   = {w0_tid, w0_addr};
    assign w1_idx   = {w1_tid, w1_addr};
    assign zero_idx = {lock_tid, zero_addr};

    // Later assignments win: w1, then w0, then the clear engine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (w1_ok) begin
                mem[w1_idx] <= w1_data;
            end
            if (w0_ok) begin
                mem[w0_idx] <= w0_data;
            end
            if (zero_we && tid_ok(lock_tid)) begin
                mem[zero_idx] <= '0;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [TID_W-1:0]          tid;
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [IDX_W-1:0]          idx;
        logic [DATA_WIDTH-1:0]     rd;

        assign tid  = r_tid[k*TID_W +: TID_W];
        assign addr = r_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign idx  = {tid, addr};

        always_comb begin
            if (!tid_ok(tid) || is_zero_reg(addr)) begin
                rd = '0;
            end else if (w0_ok && (w0_idx == idx)) begin
                rd = w0_data;
            end else if (w1_ok && (w1_idx == idx)) begin
                rd = w1_data;
            end else begin
                rd = mem[idx];
            end
        end

        assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule

// File: tb/tb_gpu_regfile_mt.sv
// tb_gpu_regfile_mt: directed and random checks of gpu_regfile_mt against a
// behavioural model (array of contexts plus a clear-progress counter).
module tb_gpu_regfile_mt;

    localparam int DW = 64;
    localparam int RW = 4;
    localparam int TH = 4;
    localparam int NR = 4;
    localparam int TW = 2;
    localparam int NREG = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w0_en, w1_en;
    logic [TW-1:0]     w0_tid, w1_tid;
    logic [RW-1:0]     w0_addr, w1_addr;
    logic [DW-1:0]     w0_data, w1_data;
    logic [NR*TW-1:0]  r_tid;
    logic [NR*RW-1:0]  r_addr;
    logic [NR*DW-1:0]  r_data;
    logic              clr_req;
    logic [TW-1:0]     clr_tid;
    logic              clr_busy, clr_done;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    gpu_regfile_mt #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (RW),
        .THREADS        (TH),
        .NREAD          (NR),
        .ZERO_REG       (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w0_en    (w0_en),
        .w0_tid   (w0_tid),
        .w0_addr  (w0_addr),
        .w0_data  (w0_data),
        .w1_en    (w1_en),
        .w1_tid   (w1_tid),
        .w1_addr  (w1_addr),
        .w1_data  (w1_data),
        .r_tid    (r_tid),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .clr_req  (clr_req),
        .clr_tid  (clr_tid),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    // Model: context contents and clear progress (0 = idle, 1..16 = clearing
    // register phase-1, 17 = done cycle).
    logic [DW-1:0] m_mem [TH][NREG];
    int            m_phase = 0;
    logic [TW-1:0] m_lock  = '0;

    function automatic bit locked(input logic [TW-1:0] t);
        return (m_phase != 0) && (t == m_lock);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < TH; t++)
                for (int r = 0; r < NREG; r++)
                    m_mem[t][r] <= '0;
            m_phase <= 0;
        end else begin
            if (w1_en && !locked(w1_tid) &&
                !(w0_en && w0_tid == w1_tid && w0_addr == w1_addr))
                m_mem[w1_tid][w1_addr] <= w1_data;
            if (w0_en && !locked(w0_tid))
                m_mem[w0_tid][w0_addr] <= w0_data;
            if (m_phase >= 1 && m_phase <= NREG)
                m_mem[m_lock][m_phase-1] <= '0;
            if (m_phase == 0) begin
                if (clr_req) begin
                    m_phase <= 1;
                    m_lock  <= clr_tid;
                end
            end else if (m_phase == NREG + 1) begin
                m_phase <= 0;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    function automatic logic [DW-1:0] exp_read(input logic [TW-1:0] t, input logic [RW-1:0] a);
        if (a == 0) return '0;
        if (locked(t)) return m_mem[t][a];
        if (w0_en && w0_tid == t && w0_addr == a) return w0_data;
        if (w1_en && w1_tid == t && w1_addr == a) return w1_data;
        return m_mem[t][a];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return r_data[k*DW +: DW];
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("clr_busy", DW'(clr_busy), DW'(m_phase != 0));
            chk("clr_done", DW'(clr_done), DW'(m_phase == NREG + 1));
            if (rst_n) begin
                for (int k = 0; k < NR; k++)
                    chk($sformatf("r_data_p%0d", k), rd(k),
                        exp_read(r_tid[k*TW +: TW], r_addr[k*RW +: RW]));
            end
        end
    end

    task automatic set_rd(input int k, input logic [TW-1:0] t, input logic [RW-1:0] a);
        r_tid[k*TW +: TW]  = t;
        r_addr[k*RW +: RW] = a;
    endtask

    task automatic idle_writes();
        w0_en = 0; w1_en = 0; clr_req = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt, done_cnt, done_cyc;

    initial begin
        rst_n = 0;
        w0_en = 0; w0_tid = 0; w0_addr = 0; w0_data = 0;
        w1_en = 0; w1_tid = 0; w1_addr = 0; w1_data = 0;
        r_tid = 0; r_addr = 0; clr_req = 0; clr_tid = 0;
        next_cycle();
        check_en = 1;
        next_cycle();
        next_cycle();
        rst_n = 1;

        // Reset: every port reads 0.
        for (int k = 0; k < NR; k++) set_rd(k, TW'(k), 4'd5);
        @(negedge clk);
        for (int k = 0; k < NR; k++) chk("reset_read", rd(k), 64'h0);

        // w0 write with same-cycle bypass, then stored.
        next_cycle();
        w0_en = 1; w0_tid = 1; w0_addr = 3; w0_data = 64'hDEAD;
        set_rd(0, 2'd1, 4'd3); set_rd(1, 2'd0, 4'd3);
        @(negedge clk);
        chk("bypass_w0", rd(0), 64'hDEAD);
        chk("other_tid_zero", rd(1), 64'h0);
        next_cycle();
        idle_writes();
        @(negedge clk);
        chk("stored_w0", rd(0), 64'hDEAD);
        chk("other_tid_zero_next", rd(1), 64'h0);

        // Same-address collision: w0 wins.
        next_cycle();
        w0_en = 1; w0_tid = 2; w0_addr = 5; w0_data = 64'h11;
        w1_en = 1; w1_tid = 2; w1_addr = 5; w1_data = 64'h22;
        set_rd(0, 2'd2, 4'd5); set_rd(1, 2'd2, 4'd6);
        @(negedge clk);
        chk("collide_bypass", rd(0), 64'h11);
        next_cycle();
        w0_data = 64'h33; w1_addr = 6; w1_data = 64'h44;
        @(negedge clk);
        chk("collide_stored", rd(0), 64'h33);
        next_cycle();
        idle_writes();
        @(negedge clk);
        chk("dual_commit_w0", rd(0), 64'h33);
        chk("dual_commit_w1", rd(1), 64'h44);

        // Hard-wired zero register.
        next_cycle();
        w0_en = 1; w0_tid = 0; w0_addr = 0; w0_data = 64'hFF;
        set_rd(0, 2'd0, 4'd0); set_rd(1, 2'd0, 4'd1);
        @(negedge clk);
        chk("zero_reg_bypass", rd(0), 64'h0);
        next_cycle();
        w0_addr = 1;
        next_cycle();
        idle_writes();
        @(negedge clk);
        chk("zero_reg_stored", rd(0), 64'h0);
        chk("r1_stored", rd(1), 64'hFF);

        // Fill T1 and T2, then clear T1.
        for (int r = 0; r < NREG; r++) begin
            next_cycle();
            w0_en = 1; w0_tid = 1; w0_addr = RW'(r); w0_data = 64'h100 + 64'(r);
            w1_en = 1; w1_tid = 2; w1_addr = RW'(r); w1_data = 64'h200 + 64'(r);
        end
        next_cycle();
        idle_writes();
        clr_req = 1; clr_tid = 1;
        next_cycle();
        clr_req = 0;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            idle_writes();
            if (c == 3) begin
                w1_en = 1; w1_tid = 1; w1_addr = 7; w1_data = 64'hBAD;
                clr_req = 1; clr_tid = 2;
                set_rd(0, 2'd1, 4'd7);
            end
            if (c == 4) begin
                w0_en = 1; w0_tid = 3; w0_addr = 2; w0_data = 64'h77;
            end
            @(negedge clk);
            if (c == 3) chk("locked_read_stored", rd(0), 64'h107);
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_cyc = c;
            end
            next_cycle();
        end
        idle_writes();
        chk("busy_cycles", 64'(busy_cnt), 64'd17);
        chk("done_cycle", 64'(done_cyc), 64'd17);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        set_rd(0, 2'd1, 4'd7); set_rd(1, 2'd2, 4'd9);
        set_rd(2, 2'd1, 4'd15); set_rd(3, 2'd3, 4'd2);
        @(negedge clk);
        chk("t1_cleared_r7", rd(0), 64'h0);
        chk("t2_intact_r9", rd(1), 64'h209);
        chk("t1_cleared_r15", rd(2), 64'h0);
        chk("t3_write_during_clear", rd(3), 64'h77);

        // Reset in clear cycle 5 aborts without a done pulse.
        next_cycle();
        clr_req = 1; clr_tid = 2;
        next_cycle();
        clr_req = 0;
        repeat (4) next_cycle();
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        chk("abort_busy_low", 64'(clr_busy), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            @(negedge clk);
            if (clr_done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_storage_t2", rd(1), 64'h0);
        chk("abort_storage_t3", rd(3), 64'h0);

        // Random traffic on all ports and threads against the model.
        for (int c = 0; c < 10000; c++) begin
            next_cycle();
            w0_en   = $urandom_range(0, 1) == 1;
            w0_tid  = TW'($urandom_range(0, TH - 1));
            w0_addr = ($urandom_range(0, 1) == 1) ? RW'($urandom_range(0, 3))
                                                  : RW'($urandom_range(0, NREG - 1));
            w0_data = {$urandom, $urandom};
            w1_en   = $urandom_range(0, 1) == 1;
            w1_tid  = ($urandom_range(0, 1) == 1) ? w0_tid : TW'($urandom_range(0, TH - 1));
            w1_addr = ($urandom_range(0, 1) == 1) ? w0_addr : RW'($urandom_range(0, NREG - 1));
            w1_data = {$urandom, $urandom};
            clr_req = $urandom_range(0, 99) == 0;
            clr_tid = TW'($urandom_range(0, TH - 1));
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 2) == 0)
                    set_rd(k, w0_tid, w0_addr);
                else if ($urandom_range(0, 2) == 0)
                    set_rd(k, w1_tid, w1_addr);
                else
                    set_rd(k, TW'($urandom_range(0, TH - 1)), RW'($urandom_range(0, NREG - 1)));
            end
        end
        next_cycle();
        idle_writes();
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
